// File: rtl/data_recv.sv
// UART 8N1 receiver for the ESP WiFi link with an ASCII '0'/'1' LED command decoder.
// Samples each bit once at mid-bit and re-arms on the half stop bit so back-to-back frames are caught.
module data_recv #(
  parameter int SYS_FRQ = 50_000_000,
  parameter int BAUD    = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_din,
  output logic [7:0] rx_dout,
  output logic       rx_vld,
  output logic       frame_err,
  output logic [1:0] led
);
  localparam int BPS  = SYS_FRQ / BAUD;
  localparam int HALF = BPS / 2;
  localparam int CW   = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0] BPS_MAX = CW'(BPS - 1);
  localparam logic [CW-1:0] HALF_V  = CW'(HALF);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt_bps;
  logic [2:0]      cnt_bit;
  logic [7:0]      shreg;
  logic            sync1, rx_s, rx_d;
  logic            fall, mid, wrap;

  // Synchroniser resets to the idle-high line level so release never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {sync1, rx_s, rx_d} <= 3'b111;
    else        {sync1, rx_s, rx_d} <= {rx_din, sync1, rx_s};
  end

  assign fall = rx_d & ~rx_s;
  assign mid  = (cnt_bps == HALF_V);
  assign wrap = (cnt_bps == BPS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_bps   <= '0;
      cnt_bit   <= '0;
      shreg     <= '0;
      rx_dout   <= '0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || wrap) cnt_bps <= '0;
      else                       cnt_bps <= cnt_bps + 1'b1;
      case (state)
        IDLE: begin
          cnt_bit <= '0;
          if (fall) state <= START;
        end
        START: begin
          // A start bit that is high again at mid-bit was a glitch
          if (mid && rx_s) state <= IDLE;
          else if (wrap) begin
            state   <= DATA;
            cnt_bit <= '0;
          end
        end
        DATA: begin
          if (mid) shreg[cnt_bit] <= rx_s;
          if (wrap) begin
            if (cnt_bit == 3'd7) state <= STOP;
            else                 cnt_bit <= cnt_bit + 3'd1;
          end
        end
        STOP: begin
          if (mid) begin
            state <= IDLE;
            if (rx_s) begin
              rx_dout <= shreg;
              rx_vld  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 2'b00;
    else if (rx_vld) begin
      case (rx_dout)
        8'd48:   led <= 2'b01;
        8'd49:   led <= 2'b10;
        default: led <= led;
      endcase
    end
  end
endmodule
